// File: rtl/ids_window_ctrl.sv
// ids_window_ctrl: closes a detection window every WINSIZE frames, starts the chi-squared evaluation, watchdogs it and debounces the alarm
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   frame_rdy   one pulse per received CAN frame
//   clear_err   clears the sticky error flags (a same-cycle set wins)
//   chi_vld     chi_in holds a valid result (honoured only while waiting)
//   chi_in      chi-squared statistic, unsigned
//   eval_start  one-cycle request to evaluate the just-closed window
//   is_attacked debounced alarm
//   overrun_err sticky: window closed while an evaluation was outstanding
//   timeout_err sticky: no result before the watchdog expired
//   win_count   accepted results, wraps at 2^16
module ids_window_ctrl #(
  parameter int          WINSIZE   = 200,
  parameter int unsigned THRESHOLD = 'h06A9,
  parameter int          CHI_WIDTH = 32,
  parameter int          RAISE_CNT = 2,
  parameter int          CLEAR_CNT = 3,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_rdy,
  input  logic                 clear_err,
  input  logic                 chi_vld,
  input  logic [CHI_WIDTH-1:0] chi_in,
  output logic                 eval_start,
  output logic                 is_attacked,
  output logic                 overrun_err,
  output logic                 timeout_err,
  output logic [15:0]          win_count
);
  localparam int FW = $clog2(WINSIZE);
  localparam int TW = $clog2(TIMEOUT);
  localparam int HW = $clog2(RAISE_CNT + 1);
  localparam int CW = $clog2(CLEAR_CNT + 1);
  typedef enum logic [1:0] {FILL, START, WAIT} state_t;
  state_t        state, state_nx;
  logic [FW-1:0] frame_cnt;
  logic [TW-1:0] timer;
  logic [HW-1:0] hit_cnt, hit_nx;
  logic [CW-1:0] clr_cnt, clr_nx;
  logic          boundary, accept, expire, over;
  assign boundary   = frame_rdy && frame_cnt == FW'(WINSIZE - 1);
  assign accept     = state == WAIT && chi_vld;
  // expiry fires on the edge that would move the timer to TIMEOUT-1, giving TIMEOUT-1 waiting cycles
  assign expire     = state == WAIT && !chi_vld && timer == TW'(TIMEOUT - 2);
  assign over       = chi_in >= CHI_WIDTH'(THRESHOLD);
  assign eval_start = state == START;
  always_comb begin
    state_nx = (state == FILL && boundary) ? START :
               (state == START)            ? WAIT  :
               (accept || expire)          ? FILL  : state;
    hit_nx   = over ? (hit_cnt == HW'(RAISE_CNT) ? hit_cnt : hit_cnt + 1'b1) : '0;
    clr_nx   = over ? '0 : (clr_cnt == CW'(CLEAR_CNT) ? clr_cnt : clr_cnt + 1'b1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FILL;
      frame_cnt   <= '0;
      timer       <= '0;
      hit_cnt     <= '0;
      clr_cnt     <= '0;
      is_attacked <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
      win_count   <= '0;
    end else begin
      state       <= state_nx;
      if (frame_rdy) frame_cnt <= boundary ? '0 : frame_cnt + 1'b1;
      timer       <= state == START ? '0 : state == WAIT ? timer + 1'b1 : timer;
      overrun_err <= (overrun_err & ~clear_err) | (boundary & (state != FILL));
      timeout_err <= (timeout_err & ~clear_err) | expire;
      if (accept) begin
        hit_cnt   <= hit_nx;
        clr_cnt   <= clr_nx;
        win_count <= win_count + 1'b1;
        if (over && hit_nx >= HW'(RAISE_CNT)) is_attacked <= 1'b1;
        else if (!over && clr_nx >= CW'(CLEAR_CNT)) is_attacked <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ids_window_ctrl.sv
// tb_ids_window_ctrl: directed plus randomized check of ids_window_ctrl against a behavioural window/alarm model
module tb_ids_window_ctrl;
  localparam int W = 4, TH = 'h06A9, RC = 2, CC = 3, TO = 8;
  logic        clk = 0, rst = 1, frame_rdy = 0, clear_err = 0, chi_vld = 0;
  logic [31:0] chi_in = '0;
  logic        eval_start, is_attacked, overrun_err, timeout_err;
  logic [15:0] win_count;
  int          n_vec = 0, n_err = 0;
  int          m_frames, m_edges, m_run_over, m_run_under;
  bit          m_pend, m_wait, m_alarm, m_ovr, m_tmo;
  logic [15:0] m_wins;

  ids_window_ctrl #(.WINSIZE(W), .THRESHOLD(TH), .CHI_WIDTH(32), .RAISE_CNT(RC),
                    .CLEAR_CNT(CC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .frame_rdy(frame_rdy), .clear_err(clear_err),
    .chi_vld(chi_vld), .chi_in(chi_in), .eval_start(eval_start),
    .is_attacked(is_attacked), .overrun_err(overrun_err),
    .timeout_err(timeout_err), .win_count(win_count));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frames = 0; m_edges = 0; m_run_over = 0; m_run_under = 0;
    m_pend = 0; m_wait = 0; m_alarm = 0; m_ovr = 0; m_tmo = 0; m_wins = '0;
  endtask

  // one clock edge: a window closes on every W-th frame; a close while busy is an overrun,
  // otherwise a start follows one cycle later and the result is awaited for TO-1 cycles
  task automatic model_step(input bit fr, input bit ce, input bit cv, input logic [31:0] ci);
    bit bnd, busy, s_ovr, s_tmo;
    bnd = fr && m_frames == W - 1;
    m_frames = (m_frames + (fr ? 1 : 0)) % W;
    busy = m_pend || m_wait;
    s_ovr = bnd && busy;
    s_tmo = 0;
    if (m_pend) begin
      m_pend = 0; m_wait = 1; m_edges = 0;
    end else if (m_wait) begin
      m_edges++;
      if (cv) begin
        m_wait = 0;
        m_wins++;
        if (ci >= TH) begin
          m_run_over++; m_run_under = 0;
          if (m_run_over >= RC) m_alarm = 1;
        end else begin
          m_run_under++; m_run_over = 0;
          if (m_run_under >= CC) m_alarm = 0;
        end
      end else if (m_edges == TO - 1) begin
        s_tmo = 1; m_wait = 0;
      end
    end else if (bnd) m_pend = 1;
    m_ovr = s_ovr | (m_ovr & !ce);
    m_tmo = s_tmo | (m_tmo & !ce);
  endtask

  task automatic compare_all();
    check("eval_start", eval_start, m_pend);
    check("is_attacked", is_attacked, m_alarm);
    check("overrun_err", overrun_err, m_ovr);
    check("timeout_err", timeout_err, m_tmo);
    check("win_count", win_count, m_wins);
  endtask

  task automatic tick(input bit fr, input bit ce, input bit cv, input logic [31:0] ci);
    frame_rdy = fr; clear_err = ce; chi_vld = cv; chi_in = ci;
    @(posedge clk);
    model_step(fr, ce, cv, ci);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    frame_rdy = 0; clear_err = 0; chi_vld = 0; chi_in = '0;
    #2 rst = 0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic window(input logic [31:0] ci);
    repeat (4) tick(1, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    tick(0, 0, 1, ci);
  endtask

  initial begin
    bit fr, ce, cv;
    logic [31:0] ci;
    do_reset();
    repeat (3) tick(1, 0, 0, 0);
    check("no_early_start", eval_start, 0);
    tick(1, 0, 0, 0);
    check("start_after_4th", eval_start, 1);
    tick(0, 0, 0, 0);
    check("start_one_cycle", eval_start, 0);
    repeat (2) tick(0, 0, 0, 0);
    tick(0, 0, 1, 'h06A9);
    check("alarm_after_1", is_attacked, 0);
    window('h0800);
    check("alarm_after_2", is_attacked, 1);
    check("win_count_2", win_count, 2);
    window('h06A8);
    window('h0000);
    check("alarm_hold_2under", is_attacked, 1);
    window('h0100);
    check("alarm_clear_3under", is_attacked, 0);
    window('h0800);
    window('h0800);
    check("alarm_reraise", is_attacked, 1);
    window('h0100);
    window('h0800);
    window('h0100);
    check("alarm_hold_restart", is_attacked, 1);
    check("win_count_10", win_count, 10);
    repeat (4) tick(1, 0, 0, 0);
    repeat (7) tick(0, 0, 0, 0);
    check("tmo_not_yet", timeout_err, 0);
    tick(0, 0, 0, 0);
    check("tmo_set", timeout_err, 1);
    tick(0, 0, 1, 'h0000);
    check("late_chi_win", win_count, 10);
    check("late_chi_alarm", is_attacked, 1);
    tick(0, 1, 0, 0);
    check("tmo_cleared", timeout_err, 0);
    repeat (8) tick(1, 0, 0, 0);
    check("overrun_set", overrun_err, 1);
    check("overrun_no_start", eval_start, 0);
    tick(0, 0, 1, 'h0800);
    check("overrun_accept", win_count, 11);
    repeat (4) tick(1, 0, 0, 0);
    repeat (2) tick(0, 0, 0, 0);
    do_reset();
    tick(0, 0, 1, 'h0800);
    check("rst_win", win_count, 0);
    check("rst_alarm", is_attacked, 0);
    repeat (3) tick(1, 0, 0, 0);
    check("rst_fill_no_start", eval_start, 0);
    tick(1, 0, 0, 0);
    check("rst_fill_start", eval_start, 1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else begin
        fr = $urandom_range(0, 2) != 0;
        ce = $urandom_range(0, 19) == 0;
        cv = $urandom_range(0, 5) == 0;
        case ($urandom_range(0, 3))
          0: ci = TH - 1;
          1: ci = TH;
          2: ci = TH + 1;
          default: ci = $urandom_range(0, 'h1000);
        endcase
        tick(fr, ce, cv, ci);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ids_window_ctrl.md
# ids_window_ctrl

Window-level sequencer and alarm controller for the CAN intrusion-detection pipeline. It counts arriving CAN frames and closes a detection window every WINSIZE frames. On each close it issues a one-cycle start strobe to the statistics datapath (degree counting, binning, chi-squared) and waits for the chi-squared result under a watchdog. It then converts successive results into a debounced `is_attacked` alarm using raise/clear hysteresis.

## Interface
Parameters:
- WINSIZE, 200: frames per detection window (≥2).
- THRESHOLD, 'h06A9: chi-squared alarm threshold; a window is "over" when chi_in ≥ THRESHOLD.
- CHI_WIDTH, 32: width of the chi-squared result.
- RAISE_CNT, 2: consecutive over windows needed to set the alarm (≥1).
- CLEAR_CNT, 3: consecutive under windows needed to clear the alarm (≥1).
- TIMEOUT, 1024: maximum cycles spent waiting for a result (≥2).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- frame_rdy  in  1  one-cycle pulse per received CAN frame (same strobe feeding the graph block).
- clear_err  in  1  synchronous pulse; clears the sticky error flags.
- chi_vld  in  1  one-cycle pulse; chi_in holds a valid result.
- chi_in  in  CHI_WIDTH  chi-squared statistic, unsigned.
- eval_start  out  1  one-cycle pulse requesting the datapath evaluate the just-closed window.
- is_attacked  out  1  debounced alarm, registered.
- overrun_err  out  1  sticky: a window closed while an evaluation was outstanding.
- timeout_err  out  1  sticky: watchdog expired in WAIT.
- win_count  out  16  windows whose result was accepted; wraps at 2^16.

## Operation
- States: FILL, START, WAIT. Reset state is FILL.
- frame_cnt, range 0..WINSIZE-1, increments on frame_rdy in every state.
  - At WINSIZE-1 with frame_rdy, it wraps to 0. This is a window boundary.
- Boundary in FILL: go to START.
- Boundary in START or WAIT: set overrun_err. The window is skipped, with no extra start and no queueing, and the state is unchanged.
- START: eval_start = 1 for exactly this cycle; clear the wait timer; go to WAIT.
- WAIT: the wait timer increments every cycle.
  - On chi_vld: evaluate the result (below), increment win_count, go to FILL.
  - Timer reaching TIMEOUT-1 without chi_vld: set timeout_err and go to FILL. Hysteresis counters and the alarm are unchanged.
  - chi_vld in the same cycle as expiry: the result is accepted; no timeout.
- chi_vld outside WAIT is ignored: no counter, flag or alarm change.
- Hysteresis uses hit_cnt and clr_cnt, each saturating at its own limit.
  - Over window: hit_cnt+1 (saturating) and clr_cnt = 0. If the new hit_cnt ≥ RAISE_CNT, set is_attacked.
  - Under window: clr_cnt+1 (saturating) and hit_cnt = 0. If the new clr_cnt ≥ CLEAR_CNT, clear is_attacked.
- Comparison is unsigned on the full CHI_WIDTH; equal to THRESHOLD counts as over.
- clear_err clears both sticky flags.
  - If a set event occurs in the same cycle, the set wins.
- Reset values: all outputs 0. frame_cnt, timer, hit_cnt and clr_cnt are 0. State is FILL.
- Asserting rst mid-WAIT abandons the evaluation. A late chi_vld after release is ignored because the block is in FILL.

## Timing
- eval_start is asserted in the cycle after the boundary frame_rdy edge. START always lasts 1 cycle.
- chi_vld sampled at edge N: is_attacked and win_count update at edge N, visible in cycle N+1. The state is FILL in cycle N+1.
- A boundary in the same cycle as an accepted chi_vld occurs while in WAIT, so it sets overrun_err.
- Timeout: WAIT entered at edge T; timeout_err is visible after edge T+TIMEOUT-1 if no chi_vld arrives.
- Back-to-back frame_rdy is legal every cycle.

## Test plan
Bench parameters: WINSIZE=4, RAISE_CNT=2, CLEAR_CNT=3, TIMEOUT=8, THRESHOLD='h06A9.

- Reset then 4 frame_rdy pulses: eval_start pulses exactly once, 1 cycle after the 4th frame; outputs stay 0 until then.
- Windows with chi_in 'h06A9, then 'h0800, each returned 3 cycles after eval_start: is_attacked rises after the 2nd result; win_count=2.
- From alarm set, results 'h06A8, 'h0000, 'h0100: is_attacked clears after the 3rd result. Sequence 'h0100, 'h0800, 'h0100: alarm holds because the clear count restarts.
- No chi_vld for 8 cycles after eval_start: timeout_err=1, is_attacked unchanged, win_count unchanged. A late chi_vld is ignored. A clear_err pulse returns the flag to 0.
- Next 4 frames while in WAIT: overrun_err=1 and no second eval_start. Result then accepted normally.
- rst low mid-WAIT, release, then chi_vld pulse: all outputs 0, state FILL, chi_vld ignored.
